bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Display-side consumer of the BCD digits produced by the team's BCD counters.
- Takes NUM_DIGITS packed BCD digits and time-multiplexes them onto the board's common-anode 7-segment display.
- Provides a refresh divider, per-frame snapshotting (no tearing), a ghost-suppression blank cycle, leading-zero blanking, and per-digit enable/decimal-point control.
- Sits between the counter/datapath registers and the top-level AN/SEG/DP pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (legal range 2..8).
- REFRESH_DIV, 100000: clk_div cycles per digit slot (must be >= 2).

Ports:
- clk_div  input  1  system clock; all state updates on the rising edge.
- BTN0  input  1  reset, synchronous, active-high.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k]; digit 0 is least significant (rightmost).
- dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit always dark.
- blank_lz  input  1  1 = suppress leading zeros.
- AN  output  NUM_DIGITS  anode selects, active-low.
- SEG  output  7  {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- scan_idx  output  3  digit currently being scanned (the registered idx).
- frame_tick  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (BTN0=1 at an edge):
  - cnt=0, idx=0, shadow BCD/dp/en/lz = 0.
  - AN = all 1, SEG = 7'b1111111, DP = 1, frame_tick = 0.
  - Applies mid-scan with the same result and overrides everything else.
- Counters:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt goes to 0, and idx goes to idx+1, wrapping from NUM_DIGITS-1 to 0.
- Snapshot:
  - In every cycle with idx==0 and cnt==0 (including the first cycle after reset release), the shadow registers load bcd_in, dp_in, digit_en and blank_lz.
  - Input changes at any other time do not affect the display until the next frame start.
- frame_tick: 1 in the cycle where idx==NUM_DIGITS-1 and cnt==REFRESH_DIV-1; 0 otherwise.
- Output pipeline: AN, SEG and DP are registered. Their value at edge t+1 is derived from cnt/idx/shadow as they stand at edge t, giving 1-cycle latency.
- Blank cycle: when cnt==0, AN = all 1 (ghost suppression). SEG/DP may hold any value in this cycle.
- Active cycles (cnt 1..REFRESH_DIV-1):
  - AN[idx] = 0 and all other AN bits = 1, unless the digit is dark.
  - A digit is dark if en[idx]==0 or it is leading-zero-blanked. A dark digit drives AN = all 1.
- Leading-zero blanking (evaluated on the shadow only):
  - Only when lz==1.
  - A digit k is blanked if it is 0 and every enabled digit above k is also 0 or blanked.
  - Digit 0 is never blanked.
  - Disabled digits are treated as blanked zeros for the purpose of the scan.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 show dash 0111111.
- DP = ~dp[idx] for a lit digit; DP = 1 when the digit is dark.
- Exactly one AN bit is low, or none, at any time.

Decomposition:
- Shared package bcd_disp_pkg:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Type/width constant for the digit index.
- One combinational sub-module: bcd_to_7seg, 4-bit BCD in, 7-bit active-low segments out.
- Scan counters, snapshot, blanking and output registers stay in bcd_display_scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset check:
   - Hold BTN0=1 for 3 cycles with bcd_in=16'h1234, then release.
   - During reset and one cycle after: AN=1111, SEG=1111111, DP=1.
   - Next: AN=1110, SEG=0011001 (the 4) for 3 cycles, then AN=1111 for 1 cycle, then AN=1101, SEG=0110000.
   - frame_tick pulses once every 16 cycles.
2. Snapshot integrity:
   - Change bcd_in from 16'h1234 to 16'h5678 while idx==2.
   - Digits 2 and 3 still show 2 and 1 in the current frame.
   - 5678 appears only after the frame_tick / idx==0, cnt==0 load.
3. Leading-zero blanking:
   - bcd_in=16'h0070, blank_lz=1: AN never selects digits 3 and 2; digit 1 shows 7, digit 0 shows 0.
   - bcd_in=16'h0000: only digit 0 is lit, showing 0.
   - Same values with blank_lz=0: all four digits are lit.
4. Enable/DP/invalid code:
   - digit_en=4'b1011, dp_in=4'b0010, bcd_in=16'hA901.
   - Digit 2 is never selected.
   - Digit 1 shows 0 with DP=0.
   - Digit 3 shows dash 0111111 with DP=1.
5. Reset mid-scan:
   - Assert BTN0 for 1 cycle at idx=2, cnt=2.
   - Next cycle: AN=1111.
   - Scan restarts at idx=0 and the shadow reloads from the current bcd_in.
6. One-hot invariant:
   - Randomised inputs over 200 frames: AN is never anything other than all-1s or exactly one 0.
   - AN is all-1s in every cnt==0-derived cycle.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 7-segment display path: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the scan index type.
package bcd_disp_pkg;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshot,
// ghost-suppression blank slot, leading-zero blanking and per-digit enable/DP.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk_div,
    input  logic                    BTN0,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [2:0]              scan_idx,
    output logic                    frame_tick
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam idx_t             IDX_LAST = idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    idx_t                    idx_reg, idx_next;

    logic [4*NUM_DIGITS-1:0] bcd_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [NUM_DIGITS-1:0]   en_reg;
    logic                    lz_reg;

    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    seg_t                    seg_reg, seg_next;
    logic                    dp_out_reg, dp_out_next;

    logic                    slot_end;
    logic                    frame_start;
    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS-1:0]   blanked;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    clear_above;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    seg_t                    cur_seg;

    assign slot_end    = (cnt_reg == CNT_LAST);
    assign frame_start = (cnt_reg == '0) && (idx_reg == '0);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // Walk from the most significant digit down; a disabled digit never
    // breaks the run of leading zeros. Digit 0 is left unblanked.
    always_comb begin
        blanked     = '0;
        clear_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            blanked[k]  = lz_reg && clear_above && (bcd_reg[4*k +: 4] == 4'd0);
            clear_above = clear_above && (!en_reg[k] || blanked[k]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign sel[gi] = (idx_reg == idx_t'(gi));
            assign lit[gi] = sel[gi] && en_reg[gi] && !blanked[gi];
        end
    endgenerate

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) begin
                cur_digit = bcd_reg[4*k +: 4];
                cur_dp    = dp_reg[k];
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // lit is one-hot or zero, so ~lit is a legal anode pattern; the first
    // cycle of every slot stays dark to hide the previous digit's ghost.
    always_comb begin
        an_next     = '1;
        seg_next    = SEG_OFF;
        dp_out_next = 1'b1;
        if ((cnt_reg != '0) && (|lit)) begin
            an_next     = ~lit;
            seg_next    = cur_seg;
            dp_out_next = ~cur_dp;
        end
    end

    always_ff @(posedge clk_div) begin
        if (BTN0) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            bcd_reg    <= '0;
            dp_reg     <= '0;
            en_reg     <= '0;
            lz_reg     <= 1'b0;
            an_reg     <= '1;
            seg_reg    <= SEG_OFF;
            dp_out_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
            dp_out_reg <= dp_out_next;
            if (frame_start) begin
                bcd_reg <= bcd_in;
                dp_reg  <= dp_in;
                en_reg  <= digit_en;
                lz_reg  <= blank_lz;
            end
        end
    end

    assign AN         = an_reg;
    assign SEG        = seg_reg;
    assign DP         = dp_out_reg;
    assign scan_idx   = idx_reg;
    assign frame_tick = slot_end && (idx_reg == IDX_LAST);

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (4 digits, 4 clocks per slot).
module tb_bcd_display_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

    logic        clk_div = 1'b0;
    logic        BTN0;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic [2:0]  scan_idx;
    logic        frame_tick;

    bcd_display_scan #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk_div    (clk_div),
        .BTN0       (BTN0),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk_div = ~clk_div;

    int cyc = 0;
    always @(posedge clk_div) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         chk_an;
        bit         chk_seg;
        bit         chk_dp;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge clk_div);
    endtask

    task automatic push_reset(input int c, input string tag);
        exp_t e;
        e.cyc = c; e.chk_an = 1; e.chk_seg = 1; e.chk_dp = 1;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0; e.tag = tag;
        sb.push_back(e);
    endtask

    // n = cycles since reset release; output at n reflects slot (n/4)%4,
    // position n%4; frame_tick is high when the next slot-cycle is the last.
    task automatic push_frame(input int base, input int n_lo, input int n_hi,
                              input logic [3:0] lit, input logic [27:0] segs,
                              input logic [3:0] dpo, input string tag);
        for (int n = n_lo; n <= n_hi; n++) begin
            exp_t e;
            int   idx;
            idx = (n / 4) % 4;
            e.cyc = base + n; e.tag = tag; e.ft = (n % 16 == 14);
            e.chk_an = 1; e.an = 4'hF; e.chk_seg = 0; e.chk_dp = 0;
            e.seg = '0; e.dp = 1'b1;
            if (n % 4 != 0) begin
                e.chk_dp = 1;
                if (lit[idx]) begin
                    e.an      = ~(4'b0001 << idx);
                    e.chk_seg = 1;
                    e.seg     = segs[idx*7 +: 7];
                    e.dp      = dpo[idx];
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic push_blank_only(input int base, input int n_lo, input int n_hi);
        for (int n = n_lo; n <= n_hi; n++) begin
            exp_t e;
            e.cyc = base + n; e.tag = "rand_blank_slot"; e.ft = (n % 16 == 14);
            e.chk_an = (n % 4 == 0); e.an = 4'hF;
            e.chk_seg = 0; e.chk_dp = 0; e.seg = '0; e.dp = 1'b1;
            sb.push_back(e);
        end
    endtask

    exp_t mon_e;
    logic bad;

    always @(negedge clk_div) begin
        if (cyc > 0) begin
            checks++;
            if (!$onehot0(~AN)) begin
                errors++;
                $display("FAIL onehot cyc=%0d AN=%b required all ones or exactly one zero", cyc, AN);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            bad = (mon_e.cyc != cyc) || (frame_tick !== mon_e.ft)
                || (mon_e.chk_an  && (AN  !== mon_e.an))
                || (mon_e.chk_seg && (SEG !== mon_e.seg))
                || (mon_e.chk_dp  && (DP  !== mon_e.dp));
            if (bad) begin
                errors++;
                $display("FAIL %s cyc=%0d (exp cyc %0d) got AN=%b SEG=%b DP=%b ft=%b required AN=%b SEG=%b DP=%b ft=%b (chk an/seg/dp=%0d%0d%0d)",
                         mon_e.tag, cyc, mon_e.cyc, AN, SEG, DP, frame_tick,
                         mon_e.an, mon_e.seg, mon_e.dp, mon_e.ft,
                         mon_e.chk_an, mon_e.chk_seg, mon_e.chk_dp);
            end
        end
    end

    initial begin
        int b;
        int b2;
        BTN0 = 1'b1; bcd_in = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; blank_lz = 1'b0;
        for (int c = 1; c <= 3; c++) push_reset(c, "reset_hold");
        wait_neg(3);
        BTN0 = 1'b0;
        b = 4;
        push_reset(b, "reset_release");
        push_frame(b,   0,  15, 4'hF,    {S1, S2, S3, S4}, 4'hF,    "f0_1234");
        push_frame(b,  16,  31, 4'hF,    {S5, S6, S7, S8}, 4'hF,    "f1_5678");
        push_frame(b,  32,  47, 4'b0011, {S0, S0, S7, S0}, 4'hF,    "f2_lz_0070");
        push_frame(b,  48,  63, 4'b0001, {S0, S0, S0, S0}, 4'hF,    "f3_lz_0000");
        push_frame(b,  64,  79, 4'hF,    {S0, S0, S0, S0}, 4'hF,    "f4_nolz_0000");
        push_frame(b,  80,  95, 4'b1011, {SD, S9, S0, S1}, 4'b1101, "f5_en_dp_dash");
        push_frame(b,  96, 111, 4'b0011, {S9, S0, S3, S0}, 4'hF,    "f6_disabled_lz");
        push_frame(b, 112, 121, 4'hF,    {S4, S3, S2, S1}, 4'hF,    "f7_4321");
        push_reset(b + 122, "reset_mid_scan");

        wait_neg(b + 8);   bcd_in = 16'h5678;
        wait_neg(b + 20);  bcd_in = 16'h0070; blank_lz = 1'b1;
        wait_neg(b + 36);  bcd_in = 16'h0000;
        wait_neg(b + 52);  blank_lz = 1'b0;
        wait_neg(b + 68);  digit_en = 4'b1011; dp_in = 4'b0010; bcd_in = 16'hA901;
        wait_neg(b + 84);  digit_en = 4'b0111; dp_in = 4'b0000; bcd_in = 16'h9030; blank_lz = 1'b1;
        wait_neg(b + 100); digit_en = 4'hF; blank_lz = 1'b0; bcd_in = 16'h4321;
        wait_neg(b + 121); BTN0 = 1'b1; bcd_in = 16'h8765;
        wait_neg(b + 122); BTN0 = 1'b0;
        b2 = b + 123;
        push_reset(b2, "reset_mid_release");
        push_frame(b2, 0, 15, 4'hF, {S8, S7, S6, S5}, 4'hF, "restart_8765");

        wait_neg(b2 + 15);
        push_blank_only(b2, 16, 16 + 200 * 16 - 1);
        for (int i = 0; i < 200 * 16; i++) begin
            bcd_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            blank_lz = 1'($urandom);
            @(negedge clk_div);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_div);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expected entries left unmatched, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
